// File: rtl/seq_1101_tx_if.sv
// Handshake bundle for the serial pattern burst transmitter.
// The requester drives start/count; the transmitter drives the serial stream and status.
`timescale 1ns/1ps
interface seq_1101_tx_if;
   logic       start;
   logic [3:0] count;
   logic       x;
   logic       x_valid;
   logic       busy;
   logic       done;
   logic [3:0] frames_left;

   modport master (
      output start, count,
      input  x, x_valid, busy, done, frames_left
   );

   modport slave (
      input  start, count,
      output x, x_valid, busy, done, frames_left
   );
endinterface

// File: rtl/seq_1101_tx.sv
// Burst transmitter: sends `count` copies of PATTERN MSB first, separated by GAP idle bits,
// then pulses done for one cycle.
`timescale 1ns/1ps
module seq_1101_tx #(
   parameter logic [3:0]  PATTERN = 4'b1101,
   parameter int unsigned GAP     = 1
) (
   input  logic         clk,
   input  logic         rst,
   seq_1101_tx_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

   // GAP=0 wraps to 4'hF, but the gap state is never entered in that case.
   localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

   state_t     r_state;
   logic [1:0] r_bit_idx;
   logic [3:0] r_gap_cnt;
   logic [3:0] r_frames_left;

   logic w_last_bit;
   logic w_sending;

   assign w_last_bit = (r_bit_idx == 2'd0);
   assign w_sending  = (r_state == ST_SEND);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_bit_idx     <= 2'd3;
         r_gap_cnt     <= 4'd0;
         r_frames_left <= 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_frames_left <= bus.count;
                  r_bit_idx     <= 2'd3;
                  r_state       <= (bus.count == 4'd0) ? ST_DONE : ST_SEND;
               end
            end
            ST_SEND: begin
               // Index wraps 0 -> 3, which is exactly what a back-to-back frame needs.
               r_bit_idx <= r_bit_idx - 2'd1;
               if (w_last_bit) begin
                  if (r_frames_left <= 4'd1) begin
                     r_frames_left <= 4'd0;
                     r_state       <= ST_DONE;
                  end else begin
                     r_frames_left <= r_frames_left - 4'd1;
                     if (GAP != 0) begin
                        r_gap_cnt <= 4'd0;
                        r_state   <= ST_GAP;
                     end
                  end
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_gap_cnt <= 4'd0;
                  r_bit_idx <= 2'd3;
                  r_state   <= ST_SEND;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 4'd1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Pure decodes of registered state: no input reaches an output combinationally.
   assign bus.x           = w_sending & PATTERN[r_bit_idx];
   assign bus.x_valid     = w_sending;
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.done        = (r_state == ST_DONE);
   assign bus.frames_left = r_frames_left;
endmodule

// File: tb/tb_seq_1101_tx.sv
// Scoreboard bench for seq_1101_tx: one instance with GAP=0, one with GAP=1, shared stimulus.
// Stimulus pushes expected output items; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_seq_1101_tx;
   localparam logic [3:0] PAT = 4'b1101;

   typedef struct {
      bit         is_done;
      logic       x;
      logic [3:0] fl;
      int         cyc;
      int         busy_len;
   } item_t;

   typedef enum logic [2:0] {D0, D1, D11, D110, D1101} det_t;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       start = 1'b0;
   logic [3:0] count = 4'd0;

   int    edge_n  = 0;
   int    tests   = 0;
   int    fails   = 0;
   bit    z_chk   = 1'b0;
   int    z_count = 0;
   item_t q0[$];
   item_t q1[$];
   int    zq[$];
   int    busy_run[2];
   bit    prev_done[2];

   det_t det_state;
   logic det_z;

   seq_1101_tx_if b0 ();
   seq_1101_tx_if b1 ();

   assign b0.start = start;
   assign b0.count = count;
   assign b1.start = start;
   assign b1.count = count;

   seq_1101_tx #(.PATTERN(4'b1101), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   seq_1101_tx #(.PATTERN(4'b1101), .GAP(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Non-overlapping Moore 1101 detector fed by the GAP=1 stream.
   assign det_z = (det_state == D1101);
   always @(posedge clk or posedge rst) begin
      if (rst) det_state <= D0;
      else begin
         case (det_state)
            D0:      det_state <= b1.x ? D1    : D0;
            D1:      det_state <= b1.x ? D11   : D0;
            D11:     det_state <= b1.x ? D11   : D110;
            D110:    det_state <= b1.x ? D1101 : D0;
            default: det_state <= b1.x ? D1    : D0;
         endcase
      end
   end

   task automatic check(input string nm, input int w, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", nm, w, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string nm);
      check(nm, 0, {b0.x, b0.x_valid, b0.busy, b0.done, b0.frames_left}, 0);
      check(nm, 1, {b1.x, b1.x_valid, b1.busy, b1.done, b1.frames_left}, 0);
   endtask

   // Expected items for a burst of n frames issued when edge_n == base.
   task automatic push_burst(input int n, input int base);
      item_t it;
      for (int w = 0; w < 2; w++) begin
         int g;
         int t;
         g = w;
         t = 1;
         for (int f = 0; f < n; f++) begin
            for (int b = 3; b >= 0; b--) begin
               it.is_done  = 1'b0;
               it.x        = PAT[b];
               it.fl       = 4'(n - f);
               it.cyc      = base + t;
               it.busy_len = 0;
               if (w == 0) q0.push_back(it); else q1.push_back(it);
               t++;
            end
            if (f < n - 1) t += g;
         end
         it.is_done  = 1'b1;
         it.x        = 1'b0;
         it.fl       = 4'd0;
         it.cyc      = base + t;
         it.busy_len = (n == 0) ? 1 : 4 * n + g * (n - 1) + 1;
         if (w == 0) q0.push_back(it); else q1.push_back(it);
      end
   endtask

   task automatic mon(input int w, input logic x, input logic xv, input logic bz,
                      input logic dn, input logic [3:0] fl);
      item_t it;
      bit    have;
      if (bz) busy_run[w]++; else busy_run[w] = 0;
      if (prev_done[w]) check("idle_after_done", w, bz, 0);
      if (xv || dn) begin
         have = 1'b0;
         if (w == 0 && q0.size() > 0) begin it = q0.pop_front(); have = 1'b1; end
         if (w == 1 && q1.size() > 0) begin it = q1.pop_front(); have = 1'b1; end
         check("output_expected", w, have, 1);
         if (have) begin
            check("cycle", w, edge_n, it.cyc);
            check("done", w, dn, it.is_done);
            check("x_valid", w, xv, !it.is_done);
            if (!it.is_done) check("x", w, x, it.x);
            check("frames_left", w, fl, it.fl);
            if (it.is_done) check("busy_len", w, busy_run[w], it.busy_len);
            $display("[TB] dut%0d cyc=%0d %s x=%0b frames_left=%0d", w, edge_n,
                     dn ? "DONE" : "BIT ", x, fl);
         end
      end else begin
         check("quiet_x", w, x, 0);
      end
      prev_done[w] = dn;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, b0.x, b0.x_valid, b0.busy, b0.done, b0.frames_left);
         mon(1, b1.x, b1.x_valid, b1.busy, b1.done, b1.frames_left);
         if (z_chk && det_z) begin
            z_count++;
            check("z_expected", 1, zq.size() > 0, 1);
            if (zq.size() > 0) check("z_cycle", 1, edge_n, zq.pop_front());
         end
      end
   end

   task automatic issue(input logic [3:0] n);
      push_burst(int'(n), edge_n);
      start = 1'b1;
      count = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((b0.busy || b1.busy) && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("idle_within_budget", 0, k < 300, 1);
      @(negedge clk);
   endtask

   initial begin
      #1 rst = 1'b1;
      #2 check_zero("async_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_zero("reset_state");
      @(negedge clk);

      // count=1 with stray starts in cycles 2 and 5 (DONE), then a start in cycle 6 that must take
      issue(4'd1);
      @(negedge clk); start = 1'b1; count = 4'd7;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      issue(4'd2);
      count = 4'd9;
      wait_idle();

      issue(4'd3);
      wait_idle();
      issue(4'd0);
      wait_idle();
      issue(4'd15);
      wait_idle();

      // Abort a burst mid-SEND; no done pulse may follow
      issue(4'd3);
      @(negedge clk);
      check("pre_rst_busy", 1, b1.busy, 1);
      #2 rst = 1'b1;
      q0.delete();
      q1.delete();
      #1 check_zero("rst_mid_burst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_zero("after_abort");
      @(negedge clk);
      check_zero("no_done_after_abort");

      issue(4'd0);
      wait_idle();
      issue(4'd1);
      wait_idle();

      // Loopback into the detector: z one cycle after each frame's last bit
      z_chk = 1'b1;
      for (int f = 0; f < 5; f++) zq.push_back(edge_n + 5 + 5 * f);
      issue(4'd5);
      wait_idle();
      repeat (3) @(negedge clk);
      z_chk = 1'b0;
      check("z_pulses", 1, z_count, 5);

      check("queue_drained", 0, q0.size(), 0);
      check("queue_drained", 1, q1.size(), 0);
      check("z_queue_drained", 1, zq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout dut0: got %0d, expected %0d", 0, 1);
      $fatal(1, "timeout");
   end
endmodule
